// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed BCD display scanner with frame-aligned updates.
// Define DISPLAY_LZB_EN to blank leading zeros while showing a value.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_bcd,
  input  logic        err,
  input  logic        clr,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en,
  output logic        upd_ack
);
  typedef enum logic [1:0] {BLANK, SHOW, ERROR} state_t;
  localparam logic [15:0] TC = 16'(SCAN_DIV - 1);
  state_t state, state_n;
  logic [15:0] cnt, pend_val, disp, disp_n;
  logic [1:0] ptr, ptr_n;
  logic pend_show, pend_err, pend_show_n, pend_err_n, tc, fb, ack_n, lz;
  logic [3:0] nib, sh, er, bcd_n, en_n;
  always_comb begin
    tc = cnt == TC;
    fb = tc && ptr == 2'd0;
    ptr_n = tc ? ptr - 2'd1 : ptr;
    state_n = clr ? BLANK : (fb && pend_err) ? ERROR : (fb && pend_show) ? SHOW : state;
    disp_n = (!clr && fb && !pend_err && pend_show) ? pend_val : disp;
    ack_n = !clr && fb && (pend_err || pend_show);
    // A request arriving on a boundary only sets its flag, so it commits one frame later.
    pend_err_n = clr ? 1'b0 : err ? 1'b1 : fb ? 1'b0 : pend_err;
    pend_show_n = (clr || err) ? 1'b0 : load ? 1'b1 : (fb && !pend_err) ? 1'b0 : pend_show;
    nib = disp_n[{ptr_n, 2'b00} +: 4];
`ifdef DISPLAY_LZB_EN
    lz = (ptr_n == 2'd3 && disp_n[15:12] == 4'd0) || (ptr_n == 2'd2 && disp_n[15:8] == 8'd0)
      || (ptr_n == 2'd1 && disp_n[15:4] == 12'd0);
`else
    lz = 1'b0;
`endif
    sh = (lz || nib > 4'd9) ? 4'hF : nib;
    er = ptr_n == 2'd3 ? 4'hA : ptr_n == 2'd0 ? 4'hF : 4'hB;
    bcd_n = state_n == SHOW ? sh : state_n == ERROR ? er : 4'hF;
    en_n = state_n == BLANK ? 4'b0000 : 4'b0001 << ptr_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt <= '0;
      ptr <= 2'd3;
      pend_show <= 1'b0;
      pend_err <= 1'b0;
      pend_val <= '0;
      disp <= '0;
      bcd_out <= 4'hF;
      digit_en <= 4'b0000;
      upd_ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= tc ? 16'd0 : cnt + 16'd1;
      ptr <= ptr_n;
      pend_show <= pend_show_n;
      pend_err <= pend_err_n;
      if (load && !clr && !err) pend_val <= value_bcd;
      disp <= disp_n;
      bcd_out <= bcd_n;
      digit_en <= en_n;
      upd_ack <= ack_n;
    end
  end
endmodule
